// File: rtl/wvb_overflow_log_arb.sv
// Round-robin arbiter that funnels per-channel overflow records into one logging FIFO.
// Optional record counter on n_records is enabled by defining WVB_OVF_LOG_STATS_EN.
module wvb_overflow_log_arb #(
    parameter int P_N_CHAN     = 24,
    parameter int P_CHAN_WIDTH = 5,
    parameter int P_LTC_WIDTH  = 48
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [P_N_CHAN-1:0]                   ovf_req,
    output logic [P_N_CHAN-1:0]                   ovf_ack,
    input  logic [P_N_CHAN*P_LTC_WIDTH-1:0]       ovf_start_ltc,
    input  logic [P_N_CHAN*P_LTC_WIDTH-1:0]       ovf_end_ltc,
    input  logic                                  fifo_full,
    output logic                                  fifo_wr_en,
    output logic [P_CHAN_WIDTH+2*P_LTC_WIDTH-1:0] fifo_wr_data,
    output logic [31:0]                           n_records
);

    localparam int REC_W = P_CHAN_WIDTH + 2*P_LTC_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_WRITE,
        S_ACK,
        S_RELEASE
    } state_t;

    state_t                  state;
    logic [P_CHAN_WIDTH-1:0] grant_chan;
    logic [P_CHAN_WIDTH-1:0] last_grant;
    logic [P_CHAN_WIDTH-1:0] win;
    logic                    found;
    int                      idx;
    logic [REC_W-1:0]        rec_q;
    logic [P_LTC_WIDTH-1:0]  start_sel;
    logic [P_LTC_WIDTH-1:0]  end_sel;
    logic [P_N_CHAN-1:0]     ack_vec;

    // Scan starts just after the last granted channel and wraps around.
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= P_N_CHAN; k++) begin
            idx = int'(last_grant) + k;
            if (idx >= P_N_CHAN) begin
                idx = idx - P_N_CHAN;
            end
            if (!found && ovf_req[idx]) begin
                found = 1'b1;
                win   = idx[P_CHAN_WIDTH-1:0];
            end
        end
    end

    assign start_sel = ovf_start_ltc[int'(grant_chan)*P_LTC_WIDTH +: P_LTC_WIDTH];
    assign end_sel   = ovf_end_ltc[int'(grant_chan)*P_LTC_WIDTH +: P_LTC_WIDTH];
    assign ack_vec   = P_N_CHAN'(1) << grant_chan;

    assign fifo_wr_en   = (state == S_WRITE) && !fifo_full;
    assign fifo_wr_data = rec_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            grant_chan <= '0;
            last_grant <= P_CHAN_WIDTH'(P_N_CHAN-1);
            rec_q      <= '0;
            ovf_ack    <= '0;
        end else begin
            ovf_ack <= '0;
            unique case (state)
                S_IDLE: begin
                    if (found) begin
                        grant_chan <= win;
                        state      <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    rec_q <= {grant_chan, start_sel, end_sel};
                    state <= S_WRITE;
                end
                S_WRITE: begin
                    if (!fifo_full) begin
                        ovf_ack <= ack_vec;
                        state   <= S_ACK;
                    end
                end
                S_ACK: begin
                    last_grant <= grant_chan;
                    state      <= S_RELEASE;
                end
                S_RELEASE: begin
                    // Hold off until the requester has seen its ack and let go.
                    if (!ovf_req[grant_chan]) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef WVB_OVF_LOG_STATS_EN
    logic [31:0] n_rec_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_rec_q <= '0;
        end else if (fifo_wr_en && (n_rec_q != 32'hFFFF_FFFF)) begin
            n_rec_q <= n_rec_q + 32'd1;
        end
    end

    assign n_records = n_rec_q;
`else
    assign n_records = '0;
`endif

endmodule

// File: tb/tb_wvb_overflow_log_arb.sv
// Directed bench for wvb_overflow_log_arb: vector table of single grants
// plus hand-written round-robin, reset and counter sequences.
module tb_wvb_overflow_log_arb;

    localparam int N  = 24;
    localparam int CW = 5;
    localparam int LW = 48;
    localparam int RW = CW + 2*LW;
`ifdef WVB_OVF_LOG_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  ovf_req = '0;
    logic [N-1:0]  ovf_ack;
    logic [N*LW-1:0] ovf_start_ltc = '0;
    logic [N*LW-1:0] ovf_end_ltc = '0;
    logic          fifo_full = 1'b0;
    logic          fifo_wr_en;
    logic [RW-1:0] fifo_wr_data;
    logic [31:0]   n_records;

    wvb_overflow_log_arb #(
        .P_N_CHAN(N),
        .P_CHAN_WIDTH(CW),
        .P_LTC_WIDTH(LW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ovf_req(ovf_req),
        .ovf_ack(ovf_ack),
        .ovf_start_ltc(ovf_start_ltc),
        .ovf_end_ltc(ovf_end_ltc),
        .fifo_full(fifo_full),
        .fifo_wr_en(fifo_wr_en),
        .fifo_wr_data(fifo_wr_data),
        .n_records(n_records)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int nrec  = 0;

    typedef struct {
        int          ch;
        logic [LW-1:0] s;
        logic [LW-1:0] e;
        int          stall;
        int          hold;
    } vec_t;

    vec_t vecs[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_n();
        return STATS ? 32'(nrec) : 32'd0;
    endfunction

    task automatic set_ltc(input int ch, input logic [LW-1:0] s,
                           input logic [LW-1:0] e);
        ovf_start_ltc[ch*LW +: LW] = s;
        ovf_end_ltc[ch*LW +: LW]   = e;
    endtask

    // Wait for the write of channel ch, check tag and ack, then drop req.
    task automatic serve(input int ch);
        int n;
        logic [N-1:0] ack_exp;
        n = 0;
        while (!fifo_wr_en && n < 40) begin
            tick();
            n++;
        end
        if (!fifo_wr_en) begin
            tests++;
            fails++;
            $display("FAIL serve_timeout: no write for ch %0d", ch);
            return;
        end
        chk("serve_tag", 128'(fifo_wr_data[RW-1 -: CW]), 128'(ch));
        nrec++;
        tick();
        ack_exp = '0;
        ack_exp[ch] = 1'b1;
        chk("serve_ack", 128'(ovf_ack), 128'(ack_exp));
        ovf_req[ch] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [RW-1:0] exp_d;
        logic [N-1:0]  ack_exp;

        vecs[0] = '{3,  48'h10,           48'h20,           0,  0};
        vecs[1] = '{0,  48'hFFFF_FFFF_FFFF, 48'h0,          0,  0};
        vecs[2] = '{23, 48'h1234_5678_9ABC, 48'hFEDC_BA98_7654, 10, 0};
        vecs[3] = '{12, 48'hAAAA_0000_5555, 48'h0000_FFFF_0000, 0,  4};
        vecs[4] = '{1,  48'h1,            48'h2,            1,  1};
        vecs[5] = '{22, 48'hDEAD_BEEF_0001, 48'hC0FF_EE00_0002, 3,  2};

        // Reset state
        #3;
        chk("rst_wr_en", 128'(fifo_wr_en), 128'(0));
        chk("rst_ack", 128'(ovf_ack), 128'(0));
        chk("rst_data", 128'(fifo_wr_data), 128'(0));
        chk("rst_nrec", 128'(n_records), 128'(0));

        // Round robin from reset: 0, 5, 23 then re-asserted 0 after 5 and 23
        set_ltc(0, 48'h100, 48'h200);
        set_ltc(5, 48'h105, 48'h205);
        set_ltc(23, 48'h117, 48'h217);
        ovf_req[0]  = 1'b1;
        ovf_req[5]  = 1'b1;
        ovf_req[23] = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        serve(0);
        tick();
        tick();
        ovf_req[0] = 1'b1;
        serve(5);
        serve(23);
        serve(0);
        tick();
        tick();
        chk("rr_nrec", 128'(n_records), 128'(exp_n()));

        // Vector table: single requests with optional stall and slow release
        foreach (vecs[i]) begin
            exp_d = {CW'(vecs[i].ch), vecs[i].s, vecs[i].e};
            ack_exp = '0;
            ack_exp[vecs[i].ch] = 1'b1;
            set_ltc(vecs[i].ch, vecs[i].s, vecs[i].e);
            ovf_req[vecs[i].ch] = 1'b1;
            fifo_full = (vecs[i].stall > 0);
            tick();
            chk("v_grant_wr", 128'(fifo_wr_en), 128'(0));
            tick();
            set_ltc(vecs[i].ch, ~vecs[i].s, ~vecs[i].e);
            for (int s = 0; s < vecs[i].stall; s++) begin
                chk("v_stall_wr", 128'(fifo_wr_en), 128'(0));
                chk("v_stall_ack", 128'(ovf_ack), 128'(0));
                tick();
            end
            fifo_full = 1'b0;
            #1;
            chk("v_wr_en", 128'(fifo_wr_en), 128'(1));
            chk("v_wr_data", 128'(fifo_wr_data), 128'(exp_d));
            chk("v_wr_ack", 128'(ovf_ack), 128'(0));
            nrec++;
            tick();
            chk("v_ack", 128'(ovf_ack), 128'(ack_exp));
            chk("v_ack_wr", 128'(fifo_wr_en), 128'(0));
            for (int h = 0; h < vecs[i].hold; h++) begin
                tick();
                chk("v_hold_wr", 128'(fifo_wr_en), 128'(0));
                chk("v_hold_ack", 128'(ovf_ack), 128'(0));
            end
            ovf_req[vecs[i].ch] = 1'b0;
            tick();
            chk("v_rel_wr", 128'(fifo_wr_en), 128'(0));
            tick();
            chk("v_nrec", 128'(n_records), 128'(exp_n()));
        end

        // Async reset while stalled in the write state
        set_ltc(7, 48'h777, 48'h888);
        ovf_req[7] = 1'b1;
        fifo_full = 1'b1;
        tick();
        tick();
        chk("ar_stall_wr", 128'(fifo_wr_en), 128'(0));
        #2;
        rst_n = 1'b0;
        #1;
        nrec = 0;
        chk("ar_wr_en", 128'(fifo_wr_en), 128'(0));
        chk("ar_ack", 128'(ovf_ack), 128'(0));
        chk("ar_data", 128'(fifo_wr_data), 128'(0));
        chk("ar_nrec", 128'(n_records), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        fifo_full = 1'b0;
        serve(7);
        chk("ar_data_after", 128'(fifo_wr_data),
            128'({CW'(7), 48'h777, 48'h888}));
        tick();
        tick();
        for (int c = 0; c < 8; c++) begin
            chk("ar_no_dup", 128'(fifo_wr_en), 128'(0));
            tick();
        end
        chk("ar_nrec_after", 128'(n_records), 128'(exp_n()));

        // Counter saturation
`ifdef WVB_OVF_LOG_STATS_EN
        dut.n_rec_q = 32'hFFFF_FFFE;
`endif
        set_ltc(2, 48'h22, 48'h33);
        for (int r = 0; r < 3; r++) begin
            ovf_req[2] = 1'b1;
            serve(2);
            tick();
            tick();
        end
        chk("sat_nrec", 128'(n_records),
            128'(STATS ? 32'hFFFF_FFFF : 32'd0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/wvb_overflow_log_arb.md
# wvb_overflow_log_arb

Shares one overflow-logging FIFO among the per-channel waveform buffer overflow controllers of the mDOM. Each channel presents an overflow record (start LTC, end LTC) with a req/ack handshake. The arbiter grants channels round-robin, writes one tagged record per grant into the downstream logging FIFO, and acknowledges the granted channel. It sits between the N per-channel overflow controllers and the single overflow FIFO read by the readout logic.

## Interface
Parameters:
- P_N_CHAN, 24, number of requesting waveform buffer channels (2..32)
- P_CHAN_WIDTH, 5, channel tag width; must satisfy 2^P_CHAN_WIDTH >= P_N_CHAN
- P_LTC_WIDTH, 48, LTC timestamp width

Ports (the clock is `clk`; reset is `rst_n`, asynchronous, active-low):
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ovf_req  in  P_N_CHAN  per-channel request; held high until ack is seen
- ovf_ack  out  P_N_CHAN  per-channel single-cycle acknowledge
- ovf_start_ltc  in  P_N_CHAN*P_LTC_WIDTH  flattened start LTCs; channel i occupies bits [i*P_LTC_WIDTH +: P_LTC_WIDTH]
- ovf_end_ltc  in  P_N_CHAN*P_LTC_WIDTH  flattened end LTCs, same packing as ovf_start_ltc
- fifo_full  in  1  logging FIFO full
- fifo_wr_en  out  1  single-cycle FIFO write strobe
- fifo_wr_data  out  P_CHAN_WIDTH+2*P_LTC_WIDTH  record {chan, start_ltc, end_ltc}, with chan in the MSBs
- n_records  out  32  count of records written (see Configuration)

## Operation
- State machine states: S_IDLE, S_GRANT, S_WRITE, S_ACK, S_RELEASE.
- S_IDLE: if any ovf_req bit is set, select a winner and go to S_GRANT.
  - Winner: the lowest index strictly after last_grant, modulo P_N_CHAN.
  - Store the winner in grant_chan.
- S_GRANT: register the winner's start/end LTC and channel into the record register, then go to S_WRITE.
  - Inputs are sampled only here. Later input changes do not affect the record.
- S_WRITE: while fifo_full is high, stay in S_WRITE with fifo_wr_en low.
  - When fifo_full is low, pulse fifo_wr_en for one cycle with the record, and go to S_ACK.
- S_ACK: pulse ovf_ack[grant_chan] for one cycle, set last_grant <= grant_chan, and go to S_RELEASE.
- S_RELEASE: wait until ovf_req[grant_chan] is low, then go to S_IDLE.
  - This prevents double-logging from a requester that drops req one cycle after ack.
- fifo_wr_data is stable from S_WRITE entry until the next S_GRANT.
- At most one ovf_ack bit is high in any cycle. ovf_ack is never asserted without a preceding fifo_wr_en.
- A req that drops before it is granted is ignored and produces no record.
- A channel tag equal to or above P_N_CHAN is never produced.

## Timing
- Reset values:
  - fifo_wr_en = 0, ovf_ack = 0, fifo_wr_data = 0, n_records = 0
  - state = S_IDLE
  - last_grant = P_N_CHAN-1, so channel 0 has first priority after reset
- Latency with fifo_full low: req high seen in cycle 0 (S_IDLE), S_GRANT in cycle 1, fifo_wr_en in cycle 2, ovf_ack in cycle 3.
- Each cycle of fifo_full high in S_WRITE adds one cycle to this latency.
- Minimum service period per record: 5 cycles, when the requester drops req the cycle after ack.
- Simultaneous requests are served in round-robin order. No channel waits more than P_N_CHAN-1 grants.
- Reset mid-operation (rst_n low in any state): all state is cleared immediately, and any partially written record is abandoned.
  - A req still held high after reset release is served again from S_IDLE.
  - A duplicate record in this case is permitted.
- fifo_full rising in the same cycle as entry into S_WRITE: the write is held off; fifo_full is sampled every cycle.

## Configuration
- WVB_OVF_LOG_STATS_EN defined:
  - n_records increments on every fifo_wr_en.
  - It is 32-bit and saturates at 0xFFFFFFFF.
  - It is cleared only by reset.
- WVB_OVF_LOG_STATS_EN undefined: n_records is tied to 0 and no counter logic is synthesized.

## Test plan
- Single request: ch 3 req with start=0x10, end=0x20, fifo_full low.
  - fifo_wr_en in cycle 2 with data {5'd3, 48'h10, 48'h20}.
  - ovf_ack[3] in cycle 3.
  - n_records=1 (stats build).
- Round robin: ch 0, 5 and 23 request together at reset.
  - Records are written in order 0, 5, 23, each acked exactly once.
  - Re-asserting ch 0 while ch 5 is pending yields order 5 before 0.
- Backpressure: fifo_full high for 10 cycles during S_WRITE.
  - No fifo_wr_en and no ack during the stall.
  - Single write the cycle after fifo_full falls; record unchanged from S_GRANT capture.
- Slow release: requester holds req high 4 cycles after ack.
  - No second record; arbiter returns to S_IDLE the cycle after req drops.
- Async reset in S_WRITE with fifo_full high: all outputs are 0 immediately.
  - After release, the still-pending req is logged once.
- Saturation (stats build): preload the counter to 0xFFFFFFFE and log 3 records.
  - n_records reads 0xFFFFFFFF.
  - Non-stats build reads 0 throughout.
